doorlock_seq: RTL and testbench
===============================

Name: doorlock_seq

Overview:
Sequencing controller for the keypad door lock. It takes start, digit and end key events and collects a multi-digit code into a shift buffer. It compares the code against a stored value, then drives door-open and auto-relock timing, a failed-attempt counter and a lockout period. It replaces the bare start/end state machine ahead of the display decoder. Its state and display code feed the existing seg7 display path.

Parameters:
CODE_LEN, 4, number of BCD digits in a valid code (1..8)
CODE, 16'h1234, stored code as packed BCD, most significant digit first, width 4*CODE_LEN
OPEN_TICKS, 5, tick count the door stays open before auto-relock (>=1)
LOCK_TICKS, 10, tick count of lockout after MAX_FAIL consecutive failures (>=1)
MAX_FAIL, 3, consecutive failed attempts that trigger lockout (1..15)

Ports:
clk  in  1  system clock; one clock; reset is synchronous and active-low
rst  in  1  synchronous active-low reset
tick  in  1  one-cycle timebase enable from the clock divider, used for all timers
ps_start  in  1  start key, one-cycle pulse
ps_key  in  1  digit strobe, one-cycle pulse; ps_num is valid when high
ps_num  in  4  key value; 0..9 are digits, 10..15 are ignored
ps_end  in  1  enter key, one-cycle pulse
door_open  out  1  lock actuator, high while in OPEN
state_out  out  2  00 IDLE, 01 ENTRY, 10 OPEN, 11 LOCKOUT
seg_out  out  2  display code: 00 blank, 01 entering, 10 pass, 11 fail/locked
digit_cnt  out  4  digits captured in the current attempt (saturates at CODE_LEN+1)
fail_cnt  out  4  consecutive failed attempts
err_pulse  out  1  one-cycle pulse on every rejected attempt

Behaviour:
- All outputs are registered. On a clk edge with rst=0: state IDLE, door_open=0, seg_out=00, digit_cnt=0, fail_cnt=0, err_pulse=0, buffer=0, timer=0. rst=0 mid-operation aborts immediately, including OPEN and LOCKOUT.
- IDLE: ps_start causes a transition to ENTRY next cycle; the buffer and digit_cnt are cleared and seg_out=01. ps_key and ps_end are ignored.
- ENTRY, digits: on ps_key with ps_num<=9 and digit_cnt<CODE_LEN, buf <= {buf[4*CODE_LEN-5:0], ps_num} and digit_cnt+1. On ps_key with digit_cnt==CODE_LEN, the digit is discarded and digit_cnt becomes CODE_LEN+1, which marks overflow and saturates there. ps_num>9 is ignored entirely.
- ENTRY, ps_start: restarts the attempt (clears buffer and digit_cnt). fail_cnt is unchanged.
- ENTRY, ps_end:
  - Match condition is digit_cnt==CODE_LEN && buf==CODE.
  - On a match: go to OPEN, timer=OPEN_TICKS, fail_cnt=0, seg_out=10.
  - On a mismatch: err_pulse=1 for one cycle and fail_cnt+1. If the new fail_cnt==MAX_FAIL, go to LOCKOUT, timer=LOCK_TICKS, seg_out=11, fail_cnt=0. Otherwise go to IDLE with seg_out=11; seg_out holds 11 until the next ps_start.
- Same-cycle priority in ENTRY: ps_end > ps_start > ps_key. A digit arriving with ps_end is not captured.
- OPEN: door_open=1. On each tick, timer decrements. A tick with timer==1 causes a transition to IDLE next cycle, with door_open=0 and seg_out=00. All key inputs are ignored. OPEN lasts exactly OPEN_TICKS ticks.
- LOCKOUT: all key inputs are ignored and door_open=0. On each tick, timer decrements. A tick with timer==1 causes a transition to IDLE with seg_out=00.
- A tick arriving in the same cycle as entry into OPEN or LOCKOUT does not count.
- door_open asserts exactly one cycle after the accepting ps_end edge. There is no combinational path from inputs to outputs.
- The timer is wide enough for max(OPEN_TICKS, LOCK_TICKS). In IDLE and ENTRY the timer holds 0.
- The code compare uses the full 4*CODE_LEN bits.

Test Plan:
1. Correct entry: rst low for 2 cycles, then ps_start, keys 1,2,3,4, ps_end. Required: state_out 01 then 10, door_open=1 the cycle after ps_end, seg_out=10. After 5 ticks: state_out=00, door_open=0.
2. Wrong code: ps_start, keys 1,2,3,5, ps_end. Required: err_pulse for one cycle, fail_cnt=1, state_out=00, seg_out=11, door_open stays 0.
3. Lockout: three wrong attempts. Required: after the third ps_end, state_out=11, fail_cnt=0. A correct code entered during lockout is ignored. Exactly 10 ticks later, state_out=00.
4. Length edge cases:
   - keys 1,2,3: rejected.
   - keys 1,2,3,4,5: digit_cnt=5, rejected.
   - key 12 inserted mid-code: ignored; 1,2,3,4 still opens.
5. Simultaneity: ps_end and ps_key(4) in the same cycle after 1,2,3 are rejected. ps_start mid-entry, then 1,2,3,4 and ps_end, opens. A success after 2 failures resets fail_cnt to 0.
6. Reset mid-OPEN, with door_open=1: rst=0 for 1 cycle gives door_open=0, state_out=00, all counters 0 on that edge.

Source files
------------

// File: rtl/doorlock_seq.sv
// Keypad door-lock sequencer: collects a BCD code, checks it against CODE,
// then runs the door-open, failed-attempt and lockout timing. All outputs are registered.
module doorlock_seq #(
  parameter int                      CODE_LEN   = 4,
  parameter logic [4*CODE_LEN-1:0]   CODE       = 16'h1234,
  parameter int                      OPEN_TICKS = 5,
  parameter int                      LOCK_TICKS = 10,
  parameter int                      MAX_FAIL   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ps_start,
  input  logic       ps_key,
  input  logic [3:0] ps_num,
  input  logic       ps_end,
  output logic       door_open,
  output logic [1:0] state_out,
  output logic [1:0] seg_out,
  output logic [3:0] digit_cnt,
  output logic [3:0] fail_cnt,
  output logic       err_pulse
);
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ENTRY = 2'b01;
  localparam logic [1:0] S_OPEN  = 2'b10;
  localparam logic [1:0] S_LOCK  = 2'b11;

  localparam int BW   = 4*CODE_LEN;
  localparam int TMAX = (OPEN_TICKS > LOCK_TICKS) ? OPEN_TICKS : LOCK_TICKS;
  localparam int TW   = $clog2(TMAX+1);

  logic [BW-1:0]   code_buf;
  logic [BW+3:0]   shifted;
  logic [TW-1:0]   timer;
  logic [3:0]      fail_nxt;
  logic            match;
  logic            digit_ok;

  assign shifted   = {code_buf, ps_num};
  assign fail_nxt  = fail_cnt + 4'd1;
  assign match     = (digit_cnt == 4'(CODE_LEN)) && (code_buf == CODE);
  assign digit_ok  = ps_key && (ps_num <= 4'd9);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_out <= S_IDLE;
      door_open <= 1'b0;
      seg_out   <= 2'b00;
      digit_cnt <= '0;
      fail_cnt  <= '0;
      err_pulse <= 1'b0;
      code_buf  <= '0;
      timer     <= '0;
    end else begin
      err_pulse <= 1'b0;
      case (state_out)
        S_IDLE: if (ps_start) begin
          state_out <= S_ENTRY;
          code_buf  <= '0;
          digit_cnt <= '0;
          seg_out   <= 2'b01;
        end
        S_ENTRY: begin
          // ps_end wins over ps_start, which wins over a digit in the same cycle
          if (ps_end) begin
            if (match) begin
              state_out <= S_OPEN;
              door_open <= 1'b1;
              timer     <= TW'(OPEN_TICKS);
              fail_cnt  <= '0;
              seg_out   <= 2'b10;
            end else begin
              err_pulse <= 1'b1;
              seg_out   <= 2'b11;
              if (fail_nxt == 4'(MAX_FAIL)) begin
                state_out <= S_LOCK;
                timer     <= TW'(LOCK_TICKS);
                fail_cnt  <= '0;
              end else begin
                state_out <= S_IDLE;
                fail_cnt  <= fail_nxt;
              end
            end
          end else if (ps_start) begin
            code_buf  <= '0;
            digit_cnt <= '0;
          end else if (digit_ok) begin
            if (digit_cnt < 4'(CODE_LEN)) begin
              code_buf  <= shifted[BW-1:0];
              digit_cnt <= digit_cnt + 4'd1;
            end else begin
              digit_cnt <= 4'(CODE_LEN+1);
            end
          end
        end
        S_OPEN: if (tick) begin
          if (timer == TW'(1)) begin
            state_out <= S_IDLE;
            door_open <= 1'b0;
            seg_out   <= 2'b00;
            timer     <= '0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: if (tick) begin
          if (timer == TW'(1)) begin
            state_out <= S_IDLE;
            seg_out   <= 2'b00;
            timer     <= '0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_doorlock_seq.sv
// Bench for doorlock_seq: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a digit-queue model.
module tb_doorlock_seq;
  localparam int CL = 4, OPEN_T = 5, LOCK_T = 10, MAXF = 3;

  logic       clk, rst, tick, ps_start, ps_key, ps_end;
  logic [3:0] ps_num;
  logic       door_open, err_pulse;
  logic [1:0] state_out, seg_out;
  logic [3:0] digit_cnt, fail_cnt;

  doorlock_seq #(.CODE_LEN(CL), .CODE(16'h1234), .OPEN_TICKS(OPEN_T),
                 .LOCK_TICKS(LOCK_T), .MAX_FAIL(MAXF)) dut (
    .clk(clk), .rst(rst), .tick(tick), .ps_start(ps_start), .ps_key(ps_key),
    .ps_num(ps_num), .ps_end(ps_end), .door_open(door_open), .state_out(state_out),
    .seg_out(seg_out), .digit_cnt(digit_cnt), .fail_cnt(fail_cnt), .err_pulse(err_pulse));

  int n_tests = 0, n_fail = 0;
  bit armed = 0;

  initial begin clk = 0; forever #5 clk = ~clk; end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: mode 0 idle, 1 entry, 2 open, 3 lockout; digits held as a queue
  int m_mode = 0, m_fail = 0, m_left = 0, m_seg = 0;
  bit m_err = 0, m_over = 0;
  int q[$];
  logic [15:0] code_v = 16'h1234;

  function automatic bit code_ok();
    if (m_over || q.size() != CL) return 0;
    for (int i = 0; i < CL; i++)
      if (q[i] != int'(code_v[4*(CL-1-i) +: 4])) return 0;
    return 1;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_mode = 0; m_fail = 0; m_left = 0; m_seg = 0; m_err = 0; m_over = 0;
      q.delete();
      armed = 1;
    end else begin
      m_err = 0;
      case (m_mode)
        0: if (ps_start) begin m_mode = 1; q.delete(); m_over = 0; m_seg = 1; end
        1: if (ps_end) begin
             if (code_ok()) begin m_mode = 2; m_left = OPEN_T; m_fail = 0; m_seg = 2; end
             else begin
               m_err = 1; m_seg = 3; m_fail++;
               if (m_fail == MAXF) begin m_mode = 3; m_left = LOCK_T; m_fail = 0; end
               else m_mode = 0;
             end
           end else if (ps_start) begin q.delete(); m_over = 0; end
           else if (ps_key && ps_num <= 9) begin
             if (!m_over && q.size() < CL) q.push_back(int'(ps_num));
             else m_over = 1;
           end
        default: if (tick) begin
             m_left--;
             if (m_left == 0) begin m_mode = 0; m_seg = 0; end
           end
      endcase
    end
  end

  always @(negedge clk) if (armed) begin
    chk("state_out", 8'(state_out), 8'(m_mode));
    chk("door_open", 8'(door_open), 8'(m_mode == 2));
    chk("seg_out",   8'(seg_out),   8'(m_seg));
    chk("digit_cnt", 8'(digit_cnt), 8'(q.size() + int'(m_over)));
    chk("fail_cnt",  8'(fail_cnt),  8'(m_fail));
    chk("err_pulse", 8'(err_pulse), 8'(m_err));
  end

  task automatic drive(input bit s, input bit k, input logic [3:0] n, input bit e, input bit t);
    ps_start = s; ps_key = k; ps_num = n; ps_end = e; tick = t;
    @(negedge clk);
    ps_start = 0; ps_key = 0; ps_num = 0; ps_end = 0; tick = 0;
  endtask

  task automatic key(input logic [3:0] n); drive(0, 1, n, 0, 0); endtask
  task automatic ticks(input int n); for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 1); endtask
  task automatic attempt(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
    drive(1, 0, 0, 0, 0); key(a); key(b); key(c); key(d); drive(0, 0, 0, 1, 0);
  endtask

  initial begin
    rst = 0; tick = 0; ps_start = 0; ps_key = 0; ps_num = 0; ps_end = 0;
    repeat (2) @(negedge clk);
    chk("rst_state", 8'(state_out), 8'd0);
    chk("rst_fail",  8'(fail_cnt),  8'd0);
    rst = 1;

    // 1: correct code, door opens for exactly OPEN_T ticks
    drive(1, 0, 0, 0, 0);
    chk("t1_entry", 8'(state_out), 8'd1);
    key(1); key(2); key(3); key(4); drive(0, 0, 0, 1, 1);
    chk("t1_open", 8'(state_out), 8'd2);
    chk("t1_door", 8'(door_open), 8'd1);
    chk("t1_seg",  8'(seg_out),   8'd2);
    ticks(OPEN_T-1);
    chk("t1_still_open", 8'(door_open), 8'd1);
    ticks(1);
    chk("t1_relock", 8'(state_out), 8'd0);
    chk("t1_door_off", 8'(door_open), 8'd0);

    // 2: wrong code
    attempt(1, 2, 3, 5);
    chk("t2_err",  8'(err_pulse), 8'd1);
    chk("t2_fail", 8'(fail_cnt),  8'd1);
    chk("t2_seg",  8'(seg_out),   8'd3);
    chk("t2_state", 8'(state_out), 8'd0);
    drive(0, 0, 0, 0, 0);
    chk("t2_err_once", 8'(err_pulse), 8'd0);
    chk("t2_seg_hold", 8'(seg_out),   8'd3);

    // 3: lockout after third failure; keys ignored while locked
    attempt(9, 9, 9, 9);
    attempt(0, 0, 0, 0);
    chk("t3_lock", 8'(state_out), 8'd3);
    chk("t3_fail0", 8'(fail_cnt), 8'd0);
    attempt(1, 2, 3, 4);
    chk("t3_ignored", 8'(state_out), 8'd3);
    ticks(LOCK_T-1);
    chk("t3_still_lock", 8'(state_out), 8'd3);
    ticks(1);
    chk("t3_unlock", 8'(state_out), 8'd0);

    // 4: length edges, ignored non-digit, success after two failures
    drive(1, 0, 0, 0, 0); key(1); key(2); key(3); drive(0, 0, 0, 1, 0);
    chk("t4_short", 8'(err_pulse), 8'd1);
    drive(1, 0, 0, 0, 0); key(1); key(2); key(3); key(4); key(5);
    chk("t4_ovf_cnt", 8'(digit_cnt), 8'd5);
    key(6);
    chk("t4_ovf_sat", 8'(digit_cnt), 8'd5);
    drive(0, 0, 0, 1, 0);
    chk("t4_long", 8'(fail_cnt), 8'd2);
    drive(1, 0, 0, 0, 0); key(1); key(2); key(12); key(3); key(4); drive(0, 0, 0, 1, 0);
    chk("t4_open", 8'(state_out), 8'd2);
    chk("t4_fail_clr", 8'(fail_cnt), 8'd0);
    ticks(OPEN_T);

    // 5: ps_end beats a same-cycle digit; restart mid-entry
    drive(1, 0, 0, 0, 0); key(1); key(2); key(3); drive(0, 1, 4, 1, 0);
    chk("t5_end_wins", 8'(err_pulse), 8'd1);
    drive(1, 0, 0, 0, 0); key(7); key(8);
    drive(1, 1, 9, 0, 0);
    chk("t5_restart", 8'(digit_cnt), 8'd0);
    key(1); key(2); key(3); key(4); drive(0, 0, 0, 1, 0);
    chk("t5_open", 8'(state_out), 8'd2);

    // 6: reset while open
    rst = 0; drive(0, 0, 0, 0, 0); rst = 1;
    chk("t6_door", 8'(door_open), 8'd0);
    chk("t6_state", 8'(state_out), 8'd0);
    chk("t6_cnt", 8'(digit_cnt), 8'd0);

    // Random traffic; occasional correct-code bursts so OPEN is reached
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 19) == 0) begin
        rst = 1;
        attempt(1, 2, 3, 4);
      end else begin
        logic [3:0] n;
        n = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 5));
        drive($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, n,
              $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
      end
    end
    rst = 1;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
